// File: rtl/floor_arbiter.sv
// floor_arbiter
//   Shares one pipelined floor unit (no valid/tag/reset of its own) among
//   NREQ requesters. One request is granted per cycle, in round-robin order.
//   A shadow valid/ID pipeline runs alongside the unit, so each result is
//   routed back to the requester that issued it, LAT cycles after the accept.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_x      : packed operands, requester i owns bits [32i+31:32i]
//   req_ready  : one-hot grant (all-zero while rst is high)
//   fu_x       : operand driven to the floor unit
//   fu_y       : result coming back from the floor unit
//   rsp_valid  : one-hot response strobe (no backpressure)
//   rsp_id     : requester ID of the current response
//   rsp_y      : floor result (fu_y passed through)
//   busy       : high while any operation is in flight
module floor_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_x,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        fu_x,
  input  logic [31:0]        fu_y,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_y,
  output logic               busy
);

  logic [IDW-1:0] ptr_reg;
  logic [LAT-1:0] vld_reg;
  logic [IDW-1:0] id_reg [LAT];

  logic [IDW-1:0] cand_idx [NREQ];
  logic [NREQ-1:0] cand_vld;
  logic [31:0]    req_x_arr [NREQ];

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           accept;
  logic [IDW-1:0] ptr_next;

  // Candidate gi is the requester gi positions above ptr, wrapped modulo
  // NREQ. The subtract-based wrap keeps non-power-of-2 NREQ correct.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ?
                            IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
      assign cand_vld[gi] = req_valid[cand_idx[gi]];
      assign req_x_arr[gi] = req_x[32*gi +: 32];
    end
  endgenerate

  // Walk the candidates from the far end down, so the nearest valid one
  // (smallest offset from ptr) is the one left standing.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // No grant is offered while in reset.
  assign accept = grant_found & ~rst;

  always_comb begin
    req_ready = '0;
    fu_x      = 32'h0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      fu_x                 = req_x_arr[grant_idx];
    end
  end

  assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg    <= '0;
      vld_reg[0] <= 1'b0;
    end else begin
      if (accept) begin
        ptr_reg <= ptr_next;
      end
      vld_reg[0] <= accept;
    end
  end

  // IDs carry no reset: they are only looked at when the matching valid is set.
  always_ff @(posedge clk) begin
    id_reg[0] <= grant_idx;
  end

  generate
    for (gi = 1; gi < LAT; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_reg[gi] <= 1'b0;
        end else begin
          vld_reg[gi] <= vld_reg[gi-1];
        end
      end

      always_ff @(posedge clk) begin
        id_reg[gi] <= id_reg[gi-1];
      end
    end
  endgenerate

  // Whatever the floor unit holds after reset is garbage; the cleared valid
  // pipeline keeps it from ever being presented as a response.
  always_comb begin
    rsp_valid = '0;
    if (vld_reg[LAT-1]) begin
      rsp_valid[id_reg[LAT-1]] = 1'b1;
    end
  end

  assign rsp_id = id_reg[LAT-1];
  assign rsp_y  = fu_y;
  assign busy   = |vld_reg;

endmodule

// File: tb/tb_floor_arbiter.sv
// Testbench for floor_arbiter. Contains a stand-in 2-stage floor unit and a
// transaction-level reference model (pointer as an integer, in-flight
// operations as a queue of {due cycle, id, expected result}).
module tb_floor_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        fu_x;
  logic [31:0]        fu_y;
  logic [NREQ-1:0]    rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_y;
  logic               busy;

  floor_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .fu_x      (fu_x),
    .fu_y      (fu_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference IEEE-754 single floor on raw bits.
  function automatic logic [31:0] fp_floor(input logic [31:0] x);
    int e;
    logic [31:0] mask;
    logic [31:0] unit;
    if (x[30:23] == 8'hFF) return x;          // inf / NaN
    if (x[30:0] == 31'h0) return x;           // +/- zero
    if (x[30:23] < 8'd127) return x[31] ? 32'hBF800000 : 32'h00000000;
    e = int'(x[30:23]) - 127;
    if (e >= 23) return x;                    // already integral
    unit = 32'h1 << (23 - e);
    mask = unit - 32'h1;
    if ((x & mask) == 32'h0) return x;
    if (!x[31]) return x & ~mask;
    return (x & ~mask) + unit;                // carry may bump the exponent
  endfunction

  // Stand-in floor unit: two unreset pipeline registers.
  logic [31:0] fu_s1, fu_s2;
  always @(posedge clk) begin
    fu_s1 <= fp_floor(fu_x);
    fu_s2 <= fu_s1;
  end
  assign fu_y = fu_s2;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } ent_t;

  ent_t q[$];
  int   model_ptr;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   rsp_seen;

  logic [NREQ-1:0] last_rdy;
  logic [NREQ-1:0] last_rv;
  logic [31:0]     last_y;
  logic [IDW-1:0]  last_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check at the falling edge, then advance
  // the reference model across the rising edge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] x, input logic r);
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    rst       = r;
    req_valid = v;
    req_x     = x;
    @(negedge clk);
    g = -1;
    if (!r) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (model_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) chk("fu_x", fu_x, x[g*32 +: 32]);
    if (!r) begin
      exp_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) exp_rv[q[0].id] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != '0) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_y", rsp_y, q[0].y);
      end
      chk("busy", 32'(busy), 32'(q.size() > 0));
    end
    last_rdy = req_ready;
    last_rv  = rsp_valid;
    last_y   = rsp_y;
    last_id  = rsp_id;
    if (rsp_valid != '0) rsp_seen++;
    $display("cycle=%0d rst=%0b valid=%b ready=%b fu_x=%h rsp_valid=%b rsp_id=%0d rsp_y=%h busy=%0b",
             cyc, r, v, req_ready, fu_x, rsp_valid, rsp_id, rsp_y, busy);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      model_ptr = 0;
    end else begin
      ent_t e;
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (g >= 0) begin
        e.due = cyc + 1 + LAT - 1;
        e.due = cyc + LAT;
        e.id  = g;
        e.y   = fp_floor(x[g*32 +: 32]);
        q.push_back(e);
        model_ptr = (g + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  function automatic logic [NREQ*32-1:0] slot(input int i, input logic [31:0] val);
    logic [NREQ*32-1:0] r;
    r = '0;
    r[i*32 +: 32] = val;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0: ;
      1: r[30:23] = 8'(120 + $urandom_range(0, 12));
      default: r[30:23] = 8'(127 + $urandom_range(0, 24));
    endcase
    return r;
  endfunction

  logic [NREQ*32-1:0] all_x;
  int accepts;

  initial begin
    n_checks = 0; n_errors = 0; rsp_seen = 0; cyc = 0; model_ptr = 0;
    rst = 1'b1; req_valid = '0; req_x = '0;
    all_x = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

    // Reset with all requesters asking: no grant may appear.
    step('1, all_x, 1'b1);
    step('1, all_x, 1'b1);
    step('0, '0, 1'b0);
    chk("reset_rsp_valid", 32'(last_rv), 32'h0);

    // Single positive request.
    step(4'b0001, slot(0, 32'h40200000), 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("single_rsp_valid", 32'(last_rv), 32'h1);
    chk("single_rsp_y", last_y, 32'h40000000);
    step('0, '0, 1'b0);

    // Two negative operands back to back from requester 2.
    step(4'b0100, slot(2, 32'hC0200000), 1'b0);
    step(4'b0100, slot(2, 32'hBF000000), 1'b0);
    step('0, '0, 1'b0);
    chk("neg0_rsp_y", last_y, 32'hC0400000);
    chk("neg0_rsp_id", 32'(last_id), 32'd2);
    step('0, '0, 1'b0);
    chk("neg1_rsp_y", last_y, 32'hBF800000);
    chk("neg1_rsp_valid", 32'(last_rv), 32'h4);

    // Fairness from a freshly reset pointer.
    step('0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step('1, all_x, 1'b0);
      chk("rr_order", 32'(last_rdy), 32'(1 << (i % NREQ)));
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // Pointer resume: after granting 1, requester 3 precedes 0.
    step(4'b0010, all_x, 1'b0);
    step(4'b1001, all_x, 1'b0);
    chk("ptr_resume", 32'(last_rdy), 32'h8);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // Reset while an operation is in flight.
    step(4'b0001, slot(0, 32'h3F400000), 1'b0);
    step('0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 1'b0);
      chk("flush_no_rsp", 32'(last_rv), 32'h0);
    end
    step('1, all_x, 1'b0);
    chk("ptr_after_reset", 32'(last_rdy), 32'h1);
    step('0, '0, 1'b0);
    step(4'b0010, slot(1, 32'h3F800000), 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("post_reset_y", last_y, 32'h3F800000);
    step('0, '0, 1'b0);

    // Random back-to-back stream of 20 accepts.
    rsp_seen = 0;
    accepts  = 0;
    while (accepts < 20) begin
      logic [NREQ-1:0] v;
      logic [NREQ*32-1:0] x;
      v = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) x[i*32 +: 32] = rand_op();
      if (v != '0) accepts++;
      step(v, x, 1'b0);
    end
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0);
    chk("stream_rsp_count", 32'(rsp_seen), 32'd20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
